u_dec: RTL and testbench

Streaming unary-/thermometer-code decoder sitting directly downstream of the unary admission check `u`. It accepts W-bit vectors over a valid/ready handshake, classifies each vector (standard code, complemented code, or invalid), and emits the binary run-length with a per-beat error flag. Output is registered behind a 2-entry skid buffer, so full throughput is sustained under backpressure. Invalid vectors are reported, never dropped.

---
 rtl/u_dec.sv | 160 ++++++++++++++++
 tb/tb_u_dec.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/u_dec.sv
// Streaming unary/thermometer decoder with 2-entry skid buffer on the output.
// Optional saturating invalid-beat counter enabled by defining U_DEC_ERR_CNT_EN.
module u_dec #(
   parameter int W                     = 16,
   parameter bit P_ADMIT_COMPLIMENT_EN = 1'b0,
   localparam int CW                   = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [W-1:0]  i_x,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [CW-1:0] o_count,
   output logic          o_is_compliment,
`ifdef U_DEC_ERR_CNT_EN
   input  logic          i_err_clr,
   output logic [7:0]    o_err_cnt,
`endif
   output logic          o_err
);

   logic [W-1:0]  x_inv;
   logic          std_ok;
   logic          cmp_ok;
   logic [CW-1:0] pop_std;
   logic [CW-1:0] pop_inv;
   logic [CW-1:0] cls_count;
   logic          cls_cmp;
   logic          cls_err;

   // A thermometer code has no 1 above a 0: x & (x+1) == 0. All-ones is
   // excluded because k is capped at W-1.
   always_comb begin
      x_inv   = ~i_x;
      std_ok  = ((i_x & (i_x + W'(1))) == '0) && (i_x != '1);
      cmp_ok  = P_ADMIT_COMPLIMENT_EN && ((x_inv & (x_inv + W'(1))) == '0) && (x_inv != '1);
      pop_std = '0;
      pop_inv = '0;
      for (int i = 0; i < W; i++) begin
         pop_std = pop_std + CW'(i_x[i]);
         pop_inv = pop_inv + CW'(x_inv[i]);
      end
      cls_count = '0;
      cls_cmp   = 1'b0;
      cls_err   = 1'b0;
      if (std_ok) begin
         cls_count = pop_std;
      end else if (cmp_ok) begin
         cls_count = pop_inv;
         cls_cmp   = 1'b1;
      end else begin
         cls_err   = 1'b1;
      end
   end

   logic          out_vld_q, out_vld_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic          out_cmp_q, out_cmp_d;
   logic          out_err_q, out_err_d;
   logic          skd_vld_q, skd_vld_d;
   logic [CW-1:0] skd_cnt_q, skd_cnt_d;
   logic          skd_cmp_q, skd_cmp_d;
   logic          skd_err_q, skd_err_d;
   logic          rdy_q, rdy_d;
   logic          accept;
   logic          emit;

   always_comb begin
      accept    = i_valid & rdy_q;
      emit      = out_vld_q & i_ready;
      out_vld_d = out_vld_q;
      out_cnt_d = out_cnt_q;
      out_cmp_d = out_cmp_q;
      out_err_d = out_err_q;
      skd_vld_d = skd_vld_q;
      skd_cnt_d = skd_cnt_q;
      skd_cmp_d = skd_cmp_q;
      skd_err_d = skd_err_q;

      if (emit && skd_vld_q) begin
         out_cnt_d = skd_cnt_q;
         out_cmp_d = skd_cmp_q;
         out_err_d = skd_err_q;
         skd_vld_d = 1'b0;
      end else if (emit) begin
         out_vld_d = 1'b0;
      end

      // rdy_q is low whenever the skid is full, so accept never collides
      // with a skid-to-output move.
      if (accept) begin
         if (!out_vld_q || emit) begin
            out_vld_d = 1'b1;
            out_cnt_d = cls_count;
            out_cmp_d = cls_cmp;
            out_err_d = cls_err;
         end else begin
            skd_vld_d = 1'b1;
            skd_cnt_d = cls_count;
            skd_cmp_d = cls_cmp;
            skd_err_d = cls_err;
         end
      end
      rdy_d = !skd_vld_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         out_cnt_q <= '0;
         out_cmp_q <= 1'b0;
         out_err_q <= 1'b0;
         skd_vld_q <= 1'b0;
         skd_cnt_q <= '0;
         skd_cmp_q <= 1'b0;
         skd_err_q <= 1'b0;
         rdy_q     <= 1'b1;
      end else begin
         out_vld_q <= out_vld_d;
         out_cnt_q <= out_cnt_d;
         out_cmp_q <= out_cmp_d;
         out_err_q <= out_err_d;
         skd_vld_q <= skd_vld_d;
         skd_cnt_q <= skd_cnt_d;
         skd_cmp_q <= skd_cmp_d;
         skd_err_q <= skd_err_d;
         rdy_q     <= rdy_d;
      end
   end

   assign o_ready         = rdy_q;
   assign o_valid         = out_vld_q;
   assign o_count         = out_cnt_q;
   assign o_is_compliment = out_cmp_q;
   assign o_err           = out_err_q;

`ifdef U_DEC_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Clear wins over the old value but still counts a same-cycle invalid beat.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (i_err_clr) begin
         err_cnt_d = (accept && cls_err) ? 8'd1 : 8'd0;
      end else if (accept && cls_err && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_u_dec.sv
// Scoreboard bench for u_dec: standard-mode and complement-mode instances share
// one stimulus stream; a reference classifier predicts each accepted beat.
module tb_u_dec;
   localparam int W  = 16;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_valid = 1'b0;
   logic [W-1:0]  i_x = '0;
   logic          i_ready = 1'b0;
   logic          i_err_clr = 1'b0;
   logic          o_ready0, o_valid0, o_cmp0, o_err0;
   logic          o_ready1, o_valid1, o_cmp1, o_err1;
   logic [CW-1:0] o_count0, o_count1;
   logic [7:0]    o_err_cnt0, o_err_cnt1;

   int tests = 0;
   int fails = 0;
   bit rnd   = 1'b0;

   always #5 clk = ~clk;

   u_dec #(.W(W), .P_ADMIT_COMPLIMENT_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready0), .i_x(i_x),
      .o_valid(o_valid0), .i_ready(i_ready), .o_count(o_count0),
      .o_is_compliment(o_cmp0),
`ifdef U_DEC_ERR_CNT_EN
      .i_err_clr(i_err_clr), .o_err_cnt(o_err_cnt0),
`endif
      .o_err(o_err0));

   u_dec #(.W(W), .P_ADMIT_COMPLIMENT_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready1), .i_x(i_x),
      .o_valid(o_valid1), .i_ready(i_ready), .o_count(o_count1),
      .o_is_compliment(o_cmp1),
`ifdef U_DEC_ERR_CNT_EN
      .i_err_clr(i_err_clr), .o_err_cnt(o_err_cnt1),
`endif
      .o_err(o_err1));

`ifndef U_DEC_ERR_CNT_EN
   assign o_err_cnt0 = 8'd0;
   assign o_err_cnt1 = 8'd0;
`endif

   // Reference: enumerate every legal code of width W and compare.
   function automatic logic [CW+1:0] ref_cls(input logic [W-1:0] x, input bit adm);
      logic [W-1:0] m;
      for (int k = 0; k < W; k++) begin
         m = W'((32'd1 << k) - 32'd1);
         if (x == m) return {CW'(k), 1'b0, 1'b0};
      end
      if (adm) begin
         for (int k = 0; k < W; k++) begin
            m = W'((32'd1 << k) - 32'd1);
            if (x == ~m) return {CW'(k), 1'b1, 1'b0};
         end
      end
      return {CW'(0), 1'b0, 1'b1};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [CW+1:0] q0[$];
   logic [CW+1:0] q1[$];
   int            m_cnt0 = 0;
   int            m_cnt1 = 0;
   bit            held = 1'b0;
   logic [CW+1:0] held0, held1;

   // Monitor/scoreboard: pop on emit, push on accept, all at the falling edge.
   always @(negedge clk) begin
      logic [CW+1:0] e;
      logic [CW+1:0] c0, c1;
      if (rst) begin
         q0.delete();
         q1.delete();
         held   = 1'b0;
         m_cnt0 = 0;
         m_cnt1 = 0;
      end else begin
         check("ready_match", {31'd0, o_ready1}, {31'd0, o_ready0});
`ifdef U_DEC_ERR_CNT_EN
         check("err_cnt0", {24'd0, o_err_cnt0}, m_cnt0);
         check("err_cnt1", {24'd0, o_err_cnt1}, m_cnt1);
`endif
         if (held && o_valid0) begin
            check("hold_stable0", {o_count0, o_cmp0, o_err0}, held0);
            check("hold_stable1", {o_count1, o_cmp1, o_err1}, held1);
         end
         if (o_valid0 && i_ready) begin
            if (q0.size() == 0) begin
               check("unexpected_beat0", {31'd0, o_valid0}, 32'd0);
            end else begin
               e = q0.pop_front();
               check("beat0", {o_count0, o_cmp0, o_err0}, e);
            end
         end
         if (o_valid1 && i_ready) begin
            if (q1.size() == 0) begin
               check("unexpected_beat1", {31'd0, o_valid1}, 32'd0);
            end else begin
               e = q1.pop_front();
               check("beat1", {o_count1, o_cmp1, o_err1}, e);
            end
         end
         held  = o_valid0 && !i_ready;
         held0 = {o_count0, o_cmp0, o_err0};
         held1 = {o_count1, o_cmp1, o_err1};
         if (i_valid && o_ready0) begin
            c0 = ref_cls(i_x, 1'b0);
            c1 = ref_cls(i_x, 1'b1);
            q0.push_back(c0);
            q1.push_back(c1);
            if (i_err_clr) m_cnt0 = c0[0] ? 1 : 0;
            else if (c0[0] && m_cnt0 < 255) m_cnt0++;
            if (i_err_clr) m_cnt1 = c1[0] ? 1 : 0;
            else if (c1[0] && m_cnt1 < 255) m_cnt1++;
         end else if (i_err_clr) begin
            m_cnt0 = 0;
            m_cnt1 = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd) begin
         i_ready = ($urandom_range(0, 3) != 0);
         i_x     = W'($urandom);
      end
   endtask

   task automatic send(input logic [W-1:0] x);
      bit acc = 1'b0;
      int n   = 0;
      i_valid = 1'b1;
      i_x     = x;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = o_ready0;
         @(posedge clk);
         #1;
         if (rnd) i_ready = ($urandom_range(0, 3) != 0);
         n++;
      end
      i_valid = 1'b0;
      if (!acc) check("send_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [W-1:0] rnd_code();
      int k;
      int sel;
      logic [W-1:0] m;
      k   = $urandom_range(0, W - 1);
      sel = $urandom_range(0, 3);
      m   = W'((32'd1 << k) - 32'd1);
      if (sel < 2) return m;
      if (sel == 2) return ~m;
      return W'($urandom);
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_valid", {31'd0, o_valid0}, 32'd0);
      check("rst_ready", {31'd0, o_ready0}, 32'd1);
      check("rst_outs", {o_count0, o_cmp0, o_err0}, 32'd0);
      check("rst_cnt", {24'd0, o_err_cnt0}, 32'd0);

      // Standard codes back to back, one cycle of latency.
      i_ready = 1'b1;
      send(16'h0000);
      check("latency_valid", {31'd0, o_valid0}, 32'd1);
      check("latency_count", {27'd0, o_count0}, 32'd0);
      send(16'h0001);
      send(16'h7FFF);
      // Complement codes: dut1 admits them, dut0 flags them.
      send(16'hFFFF);
      send(16'hFFF0);
      send(16'h8000);
      tick();
      tick();

      // Invalid beats and the error counter.
      @(negedge clk);
      i_err_clr = 1'b1;
      @(posedge clk);
      #1;
      i_err_clr = 1'b0;
      send(16'h0005);
      send(16'h00F0);
      tick();
`ifdef U_DEC_ERR_CNT_EN
      check("err_cnt_two", {24'd0, o_err_cnt0}, 32'd2);
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      check("err_cnt_clr", {24'd0, o_err_cnt0}, 32'd0);
      i_err_clr = 1'b1;
      send(16'h0005);
      i_err_clr = 1'b0;
      check("err_cnt_clr_inv", {24'd0, o_err_cnt0}, 32'd1);
      for (int i = 0; i < 300; i++) send(16'h00F0);
      tick();
      check("err_cnt_sat", {24'd0, o_err_cnt0}, 32'd255);
`endif

      // Backpressure: second beat goes to skid, then o_ready drops.
      i_ready = 1'b1;
      i_valid = 1'b1;
      i_x     = 16'h0001;
      tick();
      i_ready = 1'b0;
      i_x     = 16'h0003;
      tick();
      i_x     = 16'h0007;
      @(negedge clk);
      check("bp_ready_low", {31'd0, o_ready0}, 32'd0);
      repeat (3) tick();
      check("bp_still_low", {31'd0, o_ready0}, 32'd0);
      check("bp_out_head", {27'd0, o_count0}, 32'd1);
      i_ready = 1'b1;
      send(16'h0007);
      send(16'h000F);
      repeat (3) tick();

      // Random valid/ready traffic.
      rnd = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(0, 3) == 0) tick();
         send(rnd_code());
      end
      rnd = 1'b0;
      i_ready = 1'b1;
      repeat (4) tick();

      // Fill both entries, then reset mid-stream.
      i_ready = 1'b0;
      send(16'h0003);
      send(16'h001F);
      @(negedge clk);
      check("full_ready_low", {31'd0, o_ready0}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", {31'd0, o_valid0}, 32'd0);
      check("midrst_ready", {31'd0, o_ready0}, 32'd1);
      check("midrst_cnt", {24'd0, o_err_cnt0}, 32'd0);
      i_ready = 1'b1;
      repeat (5) tick();
      check("midrst_no_stale", {31'd0, o_valid0}, 32'd0);

      // Drain and confirm nothing was lost.
      send(16'h00FF);
      repeat (3) tick();
      check("drain0", q0.size(), 32'd0);
      check("drain1", q1.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
